// File: rtl/tdm_demux16_rx.sv
// tdm_demux16_rx: receive end of an N-slot TDM serial link.
// Tracks frame sync, demultiplexes slot bits into a frame buffer and
// publishes each completed frame as a registered word with a one-cycle
// valid pulse. Sync violations raise a one-cycle frame_err.
module tdm_demux16_rx #(
  parameter int N_SLOTS = 16,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [N_SLOTS-1:0] out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   sel,
  output logic               locked,
  output logic               frame_err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       sel_nxt;
  // The last slot bit goes straight to out, so the buffer holds N_SLOTS-1 bits.
  logic [N_SLOTS-2:0]     frame_buf, buf_nxt;
  logic                   load;
  logic                   err;

  // State register: sync tracking between HUNT and RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Slot counter, frame buffer and registered frame outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel       <= '0;
      frame_buf <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sel       <= sel_nxt;
      frame_buf <= buf_nxt;
      out_valid <= load;
      frame_err <= err;
      if (load) out <= {din, frame_buf};
    end
  end

  // Next-state logic: only beats (din_valid=1) advance anything.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    buf_nxt   = frame_buf;
    load      = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            buf_nxt[0] = din;
            sel_nxt    = SEL_W'(1);
            state_nxt  = RUN;
          end
        end
        RUN: begin
          if (sel == '0) begin
            if (frame_start) begin
              buf_nxt[0] = din;
              sel_nxt    = SEL_W'(1);
            end else begin
              // Sync lost: drop the bit and go back to hunting.
              err       = 1'b1;
              sel_nxt   = '0;
              state_nxt = HUNT;
            end
          end else if (frame_start) begin
            // Early sync: abandon the partial frame, this beat is slot 0.
            err        = 1'b1;
            buf_nxt[0] = din;
            sel_nxt    = SEL_W'(1);
          end else if (sel == LAST_SLOT) begin
            load    = 1'b1;
            sel_nxt = '0;
          end else begin
            for (int i = 1; i < N_SLOTS - 1; i++) begin
              if (sel == SEL_W'(i)) buf_nxt[i] = din;
            end
            sel_nxt = sel + SEL_W'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Output decode: locked mirrors the registered state.
  always_comb begin
    locked = (state == RUN);
  end

endmodule

// File: tb/tb_tdm_demux16_rx.sv
// Self-checking bench for tdm_demux16_rx against a frame-level reference model.
module tb_tdm_demux16_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  sel;
  logic        locked;
  logic        frame_err;

  tdm_demux16_rx #(.N_SLOTS(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .out(out), .out_valid(out_valid),
    .sel(sel), .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "in sync" flag, next slot number, collected bits.
  bit          m_sync;
  int          m_slot;
  bit          m_bits[16];
  logic [15:0] m_out;
  bit          m_ov, m_err;

  int cycle = 0;
  int ov_count = 0;
  int err_count = 0;
  int ov_cycles[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [15:0] pack_bits();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = m_bits[i];
    return w;
  endfunction

  // Model one clock with the given inputs, run the DUT one clock, compare.
  task automatic step(bit rst, bit v, bit fs, bit d);
    m_ov = 0;
    m_err = 0;
    if (rst) begin
      m_sync = 0; m_slot = 0; m_out = '0;
      foreach (m_bits[i]) m_bits[i] = 0;
    end else if (v) begin
      if (fs) begin
        if (m_sync && m_slot != 0) m_err = 1;
        m_sync = 1;
        foreach (m_bits[i]) m_bits[i] = 0;
        m_bits[0] = d;
        m_slot = 1;
      end else if (m_sync) begin
        if (m_slot == 0) begin
          m_err = 1;
          m_sync = 0;
        end else begin
          m_bits[m_slot] = d;
          m_slot++;
          if (m_slot == 16) begin
            m_out = pack_bits();
            m_ov = 1;
            m_slot = 0;
          end
        end
      end
    end
    rst_n = ~rst;
    din_valid = v;
    frame_start = fs;
    din = d;
    @(posedge clk);
    #1;
    cycle++;
    if (out_valid === 1'b1) begin
      ov_count++;
      ov_cycles.push_back(cycle);
    end
    if (frame_err === 1'b1) err_count++;
    check("out", 32'(out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("sel", 32'(sel), 32'(m_slot));
    check("locked", 32'(locked), 32'(m_sync));
    check("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic gap_cycles(int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Send slots [first..last] of word w; frame_start rides on slot 0.
  task automatic send_slots(logic [15:0] w, int first, int last, bit gaps);
    for (int s = first; s <= last; s++) begin
      if (gaps && $urandom_range(0, 1)) gap_cycles($urandom_range(1, 3));
      step(0, 1, (s == 0), w[s]);
    end
  endtask

  initial begin
    m_sync = 0; m_slot = 0; m_out = '0; m_ov = 0; m_err = 0;
    foreach (m_bits[i]) m_bits[i] = 0;

    // Reset state
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);

    // Continuous frame
    ov_count = 0; err_count = 0;
    step(0, 1, 1, 1'b1);
    check("locked_after_beat0", 32'(locked), 32'h1);
    send_slots(16'h33ff, 1, 15, 0);
    check("frame1_out", 32'(out), 32'h33ff);
    check("frame1_pulse", 32'(ov_count), 32'd1);
    check("frame1_noerr", 32'(err_count), 32'd0);
    gap_cycles(2);

    // Same frame with random gaps
    ov_count = 0;
    send_slots(16'h33ff, 0, 15, 1);
    gap_cycles(3);
    check("gap_out", 32'(out), 32'h33ff);
    check("gap_pulses", 32'(ov_count), 32'd1);

    // Back-to-back frames
    ov_cycles.delete();
    send_slots(16'h33ff, 0, 15, 0);
    check("b2b_first", 32'(out), 32'h33ff);
    send_slots(16'ha5c3, 0, 15, 0);
    check("b2b_second", 32'(out), 32'ha5c3);
    check("b2b_count", 32'(ov_cycles.size()), 32'd2);
    if (ov_cycles.size() == 2)
      check("b2b_spacing", 32'(ov_cycles[1] - ov_cycles[0]), 32'd16);

    // Early sync at slot 7
    ov_count = 0; err_count = 0;
    send_slots(16'hffff, 0, 6, 0);
    send_slots(16'h0f0f, 0, 15, 0);
    check("early_out", 32'(out), 32'h0f0f);
    check("early_pulses", 32'(ov_count), 32'd1);
    check("early_errs", 32'(err_count), 32'd1);

    // Missing frame_start at slot 0
    send_slots(16'h33ff, 0, 15, 0);
    err_count = 0;
    step(0, 1, 0, 1);
    check("lost_err", 32'(frame_err), 32'h1);
    check("lost_locked", 32'(locked), 32'h0);
    check("lost_out", 32'(out), 32'h33ff);
    for (int i = 0; i < 6; i++) step(0, 1, 0, $urandom_range(0, 1));
    check("lost_errs", 32'(err_count), 32'd1);

    // Reset at slot 9
    ov_count = 0;
    send_slots(16'h1234, 0, 8, 0);
    step(1, 1, 0, 1);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_sel", 32'(sel), 32'h0);
    send_slots(16'h1234, 10, 15, 0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_pulses", 32'(ov_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit rr = ($urandom_range(0, 199) == 0);
      bit vv = ($urandom_range(0, 3) != 0);
      bit ff = ($urandom_range(0, 15) == 0) || (m_slot == 0 && $urandom_range(0, 1));
      step(rr, vv, ff, $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
